// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: opcodes, FSM states, slice select.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package alu_ctrl_pkg;

   // Operation encoding as seen on the op input and, for logic ops, on the slice select
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_SLT  = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_NAND = 3'd5;
   localparam logic [2:0] OP_NOR  = 3'd6;
   localparam logic [2:0] OP_OR   = 3'd7;

   // Sequencer states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // All arithmetic ops drive the slice as an adder
   localparam logic [2:0] SEL_ARITH = 3'b000;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
   endfunction

   // Subtraction is a + ~b + 1: invert b and seed the carry with 1
   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_bit_counter.sv
// Bit index counter for the serial ALU: clear, increment, terminal flag at WIDTH-1.
// Latency: index updates one cycle after clear/increment; terminal flag is combinational.
// Backpressure: none; incrementing at the terminal count returns to 0 instead of wrapping past.
module alu_bit_counter #(
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_clr,
   input  logic                     i_inc,
   output logic [$clog2(WIDTH)-1:0] o_idx,
   output logic                     o_tc
);
   localparam int IW = $clog2(WIDTH);

   logic [IW-1:0] r_idx;

   assign o_tc  = (r_idx == IW'(WIDTH - 1));
   assign o_idx = r_idx;

   // Count bit positions; never run beyond WIDTH-1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx <= '0;
      end else if (i_clr || (i_inc && o_tc)) begin
         r_idx <= '0;
      end else if (i_inc) begin
         r_idx <= r_idx + 1'b1;
      end
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Sequencer feeding a 1-bit ALU slice LSB first; optional abort input under ALU_SERIAL_ABORT_EN.
// Latency: start accepted at edge 0, RUN cycles 1..WIDTH, done pulses in cycle WIDTH+1.
// Backpressure: start is taken only in IDLE; start while busy is dropped, never queued.
module alu_serial_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
`ifdef ALU_SERIAL_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             s0,
   output logic             s1,
   output logic             s2,
   output logic             a_bit,
   output logic             b_bit,
   output logic             c_bit,
   output logic             z0,
   input  logic             out_bit,
   input  logic             carry_bit,
   input  logic             z1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             overflow
);
   localparam int IW = $clog2(WIDTH);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic             r_carry;
   logic             r_z;
   logic [WIDTH-2:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_carry_out;
   logic             r_zero;
   logic             r_ovf;

   logic [IW-1:0]    w_idx;
   logic             w_tc;
   logic             w_run;
   logic             w_arith;
   logic             w_abort;
   logic             w_cout;
   logic             w_ovf;
   logic             w_slt;
   logic             w_zero;
   logic [WIDTH-1:0] w_final;
   logic [2:0]       w_sel;

`ifdef ALU_SERIAL_ABORT_EN
   assign w_abort = abort & w_run;
`else
   assign w_abort = 1'b0;
`endif

   assign w_run   = (r_state == ST_RUN);
   assign w_arith = is_arith(r_op);

   alu_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr ((r_state == ST_IDLE && start) || w_abort),
      .i_inc (w_run && !w_abort),
      .o_idx (w_idx),
      .o_tc  (w_tc)
   );

   // Slice drive: only active in RUN so the slice sees zeros while idle
   assign w_sel = w_arith ? SEL_ARITH : r_op;
   assign {s2, s1, s0} = w_run ? w_sel : 3'b000;
   assign a_bit = w_run & r_a[w_idx];
   assign b_bit = w_run & (r_b[w_idx] ^ is_sub(r_op));
   assign c_bit = w_run & r_carry;
   assign z0    = w_run & r_z;

   // Final flags formed from the MSB slice cycle; r_carry is the carry into the MSB there
   assign w_cout  = w_arith & carry_bit;
   assign w_ovf   = w_arith & (r_carry ^ carry_bit);
   assign w_slt   = out_bit ^ w_ovf;
   assign w_final = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_slt} : {out_bit, r_acc};
   assign w_zero  = (r_op == OP_SLT) ? ~w_slt : ~z1;

   // Sequencer: latch operands, step through bits, commit result at the MSB edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= OP_ADD;
         r_carry     <= 1'b0;
         r_z         <= 1'b0;
         r_acc       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a_in;
                  r_b     <= b_in;
                  r_op    <= op;
                  r_carry <= is_sub(op);
                  r_z     <= 1'b0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_abort) begin
                  r_state <= ST_IDLE;
               end else begin
                  if (!w_tc) r_acc[w_idx] <= out_bit;
                  if (w_arith) r_carry <= carry_bit;
                  r_z <= z1;
                  if (w_tc) begin
                     r_state     <= ST_DONE;
                     r_result    <= w_final;
                     r_carry_out <= w_cout;
                     r_zero      <= w_zero;
                     r_ovf       <= w_ovf;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign done      = (r_state == ST_DONE);
   assign busy      = w_run | done;
   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign zero      = r_zero;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl with a behavioural 1-bit slice and an arithmetic reference model.
// Latency: checks done arrives WIDTH+1 cycles after the accepting edge.
// Backpressure: exercises start-while-busy, reset mid-RUN and (if enabled) abort.
module tb_alu_serial_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         s0, s1, s2, a_bit, b_bit, c_bit, z0;
   logic         out_bit, carry_bit, z1;
   logic         busy, done, carry_out, zero, overflow;
   logic [W-1:0] result;
`ifdef ALU_SERIAL_ABORT_EN
   logic         abort = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef ALU_SERIAL_ABORT_EN
      .abort     (abort),
`endif
      .start     (start),
      .op        (op),
      .a_in      (a_in),
      .b_in      (b_in),
      .s0        (s0),
      .s1        (s1),
      .s2        (s2),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .c_bit     (c_bit),
      .z0        (z0),
      .out_bit   (out_bit),
      .carry_bit (carry_bit),
      .z1        (z1),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero),
      .overflow  (overflow)
   );

   // 1-bit slice: full adder for select 0, bitwise logic otherwise; zero chain ORs result bits.
   // Carry-out is left as the adder majority even for logic selects so a stray latch shows up.
   always_comb begin
      out_bit   = a_bit ^ b_bit ^ c_bit;
      carry_bit = (a_bit & b_bit) | (a_bit & c_bit) | (b_bit & c_bit);
      case ({s2, s1, s0})
         3'd3:    out_bit = a_bit ^ b_bit;
         3'd4:    out_bit = a_bit & b_bit;
         3'd5:    out_bit = ~(a_bit & b_bit);
         3'd6:    out_bit = ~(a_bit | b_bit);
         3'd7:    out_bit = a_bit | b_bit;
         default: ;
      endcase
      z1 = z0 | out_bit;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: whole-word arithmetic on the operands
   task automatic ref_alu(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic cy, output logic z, output logic v);
      logic [W:0] s;
      cy = 1'b0;
      v  = 1'b0;
      r  = '0;
      case (o)
         3'd0: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[W-1:0];
            cy = s[W];
            v  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd1, 3'd2: begin
            s  = {1'b0, a} + {1'b0, ~b} + 1;
            r  = s[W-1:0];
            cy = s[W];
            v  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            if (o == 3'd2) r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         end
         3'd3: r = a ^ b;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      z = (r == '0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {busy, done, carry_out, zero, overflow}, 0);
      chk({tag, "_drv"}, {s2, s1, s0, a_bit, b_bit, c_bit, z0}, 0);
      chk({tag, "_res"}, result, 0);
   endtask

   // Issue one op; optionally pulse start again at RUN cycle pulse_cyc (must be ignored)
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int pulse_cyc);
      logic [W-1:0] er;
      logic ec, ez, ev;
      int cyc;
      ref_alu(o, a, b, er, ec, ez, ev);
      @(negedge clk);
      op = o; a_in = a; b_in = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = ~o; a_in = ~a; b_in = ~b;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk("busy_run", busy, 1);
         start = (cyc == pulse_cyc);
      end while (!done && cyc < 40);
      start = 1'b0;
      chk("done_cycle", cyc, W + 1);
      chk($sformatf("result op%0d a%0h b%0h", o, a, b), result, er);
      chk($sformatf("carry op%0d", o), carry_out, ec);
      chk($sformatf("zero op%0d", o), zero, ez);
      chk($sformatf("ovf op%0d", o), overflow, ev);
      chk("busy_done", busy, 1);
      @(negedge clk);
      chk("idle_after", {busy, done}, 0);
      chk("res_hold", result, er);
      @(negedge clk);
      chk("no_requeue", {busy, done}, 0);
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] tbl [4];
      tbl[0] = '0; tbl[1] = W'(8'h7F); tbl[2] = W'(8'h80); tbl[3] = '1;
      if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 3)];
      return W'($urandom);
   endfunction

   initial begin
      #1;
      chk_all_zero("reset0");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_op(3'd0, 8'h7F, 8'h01, 0);
      run_op(3'd1, 8'h05, 8'h05, 0);
      run_op(3'd2, 8'h80, 8'h01, 0);
      run_op(3'd2, 8'h01, 8'h80, 0);
      run_op(3'd4, 8'hF0, 8'h3C, 0);
      run_op(3'd6, 8'hF0, 8'h3C, 0);
      run_op(3'd3, 8'hA5, 8'h0F, 3);
      chk("idle_drv", {s2, s1, s0, a_bit, b_bit, c_bit, z0}, 0);

      // Reset in the middle of RUN after a nonzero result
      run_op(3'd7, 8'h0F, 8'hF0, 0);
      @(negedge clk);
      op = 3'd0; a_in = 8'h12; b_in = 8'h34; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", {busy, done, result}, 0);
      end
      run_op(3'd0, 8'h33, 8'h44, 0);

`ifdef ALU_SERIAL_ABORT_EN
      run_op(3'd4, 8'hF0, 8'h3C, 0);
      @(negedge clk);
      op = 3'd0; a_in = 8'h11; b_in = 8'h22; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", {busy, done}, 0);
      chk("abort_keep", result, 8'h30);
      chk("abort_flags", {carry_out, zero, overflow}, 0);
      repeat (W + 2) begin
         @(negedge clk);
         chk("abort_nodone", done, 0);
      end
      run_op(3'd1, 8'h10, 8'h20, 0);
`endif

      for (int k = 0; k < 150; k++) begin
         run_op(3'($urandom_range(0, 7)), pick(), pick(), (k % 5 == 0) ? 2 + (k % 6) : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
